alu_seq: RTL and testbench

ALU_SEQ -- requirements
Module: alu_seq

---
 rtl/alu_seq.sv | 168 ++++++++++++++++
 tb/tb_alu_seq.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// ---------------------------------------------------------------------------
// alu_seq : single-request ALU with a 16-step shift-add multiplier
// rev 1.0 : initial release
// ---------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

`ifndef WORD
`define WORD 16
`endif

module alu_seq #(
  parameter int WIDTH = `WORD
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [4:0]       alu_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] z,
  output logic             op_err
);

  // Multiplier bits consumed per step so that 16 steps always cover WIDTH.
  localparam int STEP_BITS = (WIDTH + 15) / 16;

  localparam logic [4:0] OP_ADD = 5'd0;
  localparam logic [4:0] OP_SUB = 5'd1;
  localparam logic [4:0] OP_AND = 5'd2;
  localparam logic [4:0] OP_OR  = 5'd3;
  localparam logic [4:0] OP_XOR = 5'd4;
  localparam logic [4:0] OP_NOT = 5'd5;
  localparam logic [4:0] OP_SHL = 5'd6;
  localparam logic [4:0] OP_SHR = 5'd7;
  localparam logic [4:0] OP_SLT = 5'd8;
  localparam logic [4:0] OP_MUL = 5'd9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_accept;
  logic [WIDTH-1:0] r_x;
  logic [WIDTH-1:0] r_y;
  logic [WIDTH-1:0] r_acc;
  logic [3:0]       r_cnt;
  logic [WIDTH-1:0] r_z;
  logic             r_err;
  logic [WIDTH-1:0] w_alu_z;
  logic             w_alu_err;
  logic             w_slt;
  logic [3:0]       w_shamt;
  logic [WIDTH-1:0] w_acc_nxt;

  assign w_shamt = y[3:0];
  assign w_slt   = ($signed(x) < $signed(y));

  // Single-cycle operations, evaluated on the live inputs at the accept edge.
  always_comb begin
    w_alu_z   = '0;
    w_alu_err = 1'b0;
    case (alu_op)
      OP_ADD: w_alu_z = x + y;
      OP_SUB: w_alu_z = x - y;
      OP_AND: w_alu_z = x & y;
      OP_OR:  w_alu_z = x | y;
      OP_XOR: w_alu_z = x ^ y;
      OP_NOT: w_alu_z = ~x;
      OP_SHL: w_alu_z = x << w_shamt;
      OP_SHR: w_alu_z = x >> w_shamt;
      OP_SLT: w_alu_z = {{(WIDTH-1){1'b0}}, w_slt};
      OP_MUL: w_alu_z = '0;
      default: begin
        w_alu_z   = '0;
        w_alu_err = 1'b1;
      end
    endcase
  end

  // r_x is the left-shifting multiplicand, r_y the right-shifting multiplier.
  always_comb begin
    w_acc_nxt = r_acc;
    for (int j = 0; j < STEP_BITS; j++) begin
      if (r_y[j]) begin
        w_acc_nxt = w_acc_nxt + (r_x << j);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = reset_n;
        if (in_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = (alu_op == OP_MUL) ? MUL : DONE;
        end
      end
      MUL: begin
        if (r_cnt == 4'hF) begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_x   <= '0;
      r_y   <= '0;
      r_acc <= '0;
      r_cnt <= 4'd0;
      r_z   <= '0;
      r_err <= 1'b0;
    end else if (w_accept) begin
      r_x   <= x;
      r_y   <= y;
      r_acc <= '0;
      r_cnt <= 4'd0;
      if (alu_op != OP_MUL) begin
        r_z   <= w_alu_z;
        r_err <= w_alu_err;
      end
    end else if (r_state == MUL) begin
      r_acc <= w_acc_nxt;
      r_x   <= r_x << STEP_BITS;
      r_y   <= r_y >> STEP_BITS;
      r_cnt <= r_cnt + 4'd1;
      if (r_cnt == 4'hF) begin
        r_z   <= w_acc_nxt;
        r_err <= 1'b0;
      end
    end
  end

  assign z      = r_z;
  assign op_err = r_err;

endmodule

`default_nettype wire

// File: tb/tb_alu_seq.sv
// ---------------------------------------------------------------------------
// tb_alu_seq : scoreboard bench for alu_seq with directed and random traffic
// rev 1.0 : initial release
// ---------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_alu_seq;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] x = '0;
  logic [W-1:0] y = '0;
  logic [4:0]   alu_op = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] z;
  logic         op_err;

  alu_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .y         (y),
    .alu_op    (alu_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .z         (z),
    .op_err    (op_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] z;
    logic        err;
    int          rise;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  int   or_mode = 0;
  bit   last_acc = 1'b0;
  bit   prev_ov = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference: plain integer arithmetic reduced modulo 2^16.
  function automatic exp_t model(input logic [4:0] op, input logic [15:0] a, input logic [15:0] b,
                                 input int edge_n);
    exp_t   e;
    longint ua = a;
    longint ub = b;
    int     sh = int'(b[3:0]);
    int     sa = (ua >= 32768) ? int'(ua) - 65536 : int'(ua);
    int     sb = (ub >= 32768) ? int'(ub) - 65536 : int'(ub);
    e.err  = 1'b0;
    e.rise = edge_n;
    case (op)
      5'd0: e.z = 16'((ua + ub) % 65536);
      5'd1: e.z = 16'((ua - ub + 65536) % 65536);
      5'd2: e.z = a & b;
      5'd3: e.z = a | b;
      5'd4: e.z = a ^ b;
      5'd5: e.z = 16'(65535 - ua);
      5'd6: e.z = 16'((ua * (longint'(1) << sh)) % 65536);
      5'd7: e.z = 16'(ua / (longint'(1) << sh));
      5'd8: e.z = (sa < sb) ? 16'd1 : 16'd0;
      5'd9: begin
        e.z    = 16'((ua * ub) % 65536);
        e.rise = edge_n + 16;
      end
      default: begin
        e.z   = 16'd0;
        e.err = 1'b1;
      end
    endcase
    return e;
  endfunction

  // Drive one cycle of request inputs; record an expectation if it is accepted.
  task automatic cycle(input bit v, input logic [4:0] op, input logic [15:0] a, input logic [15:0] b);
    int acc_edge;
    @(posedge clk);
    #1;
    in_valid = v;
    alu_op   = op;
    x        = a;
    y        = b;
    @(negedge clk);
    last_acc = 1'b0;
    if (in_valid && in_ready) begin
      last_acc = 1'b1;
      acc_edge = cyc + 1;
      #1;
      q.push_back(model(op, a, b, acc_edge));
    end
  endtask

  task automatic send(input logic [4:0] op, input logic [15:0] a, input logic [15:0] b);
    int n = 0;
    do begin
      cycle(1'b1, op, a, b);
      n++;
    end while (!last_acc && n < 100);
    if (!last_acc) chk(1'b0, "accept_timeout", 32'(n), 32'd0);
    cycle(1'b0, 5'($urandom), 16'($urandom), 16'($urandom));
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((q.size() != 0 || !in_ready) && n < 300) begin
      cycle(1'b0, 5'd0, 16'd0, 16'd0);
      n++;
    end
    chk(q.size() == 0 && in_ready, "drain", 32'(q.size()), 32'd0);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (or_mode)
        0:       out_ready = ($urandom % 4) != 0;
        1:       out_ready = 1'b0;
        default: out_ready = 1'b1;
      endcase
    end
  end

  // Monitor: handshake tracking, latency, result and hold-stability checks.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        prev_ov = 1'b0;
      end else begin
        chk(in_ready == (q.size() == 0), "in_ready", 32'(in_ready), 32'(q.size() == 0));
        if (out_valid) begin
          if (q.size() == 0) begin
            chk(1'b0, "unexpected_out", 32'({op_err, z}), 32'd0);
          end else begin
            if (!prev_ov) chk(cyc == q[0].rise, "latency", 32'(cyc), 32'(q[0].rise));
            chk(z == q[0].z && op_err == q[0].err, "result", 32'({op_err, z}), 32'({q[0].err, q[0].z}));
            if (out_ready) void'(q.pop_front());
          end
        end else if (q.size() != 0 && cyc >= q[0].rise) begin
          chk(1'b0, "missing_out", 32'(cyc), 32'(q[0].rise));
        end
        prev_ov = out_valid;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [15:0] corners [5];

  initial begin
    corners[0] = 16'h0000;
    corners[1] = 16'hFFFF;
    corners[2] = 16'h8000;
    corners[3] = 16'h7FFF;
    corners[4] = 16'h0001;

    #12;
    chk(out_valid == 1'b0, "rst_out_valid", 32'(out_valid), 32'd0);
    chk(z == '0, "rst_z", 32'(z), 32'd0);
    chk(op_err == 1'b0, "rst_op_err", 32'(op_err), 32'd0);
    chk(in_ready == 1'b0, "rst_in_ready", 32'(in_ready), 32'd0);
    repeat (2) @(posedge clk);
    #2;
    reset_n = 1'b1;

    or_mode = 2;
    send(5'd0, 16'h7FFF, 16'h0001);
    wait_idle();
    or_mode = 0;
    send(5'd1, 16'h0000, 16'h0001); wait_idle();
    send(5'd9, 16'h0123, 16'h0045); wait_idle();
    send(5'd9, 16'hFFFF, 16'hFFFF); wait_idle();
    send(5'd9, 16'h1234, 16'h0000); wait_idle();
    send(5'd9, 16'h0000, 16'hBEEF); wait_idle();
    send(5'd8, 16'hFFFE, 16'h0001); wait_idle();
    send(5'd7, 16'h8000, 16'h0013); wait_idle();
    send(5'd6, 16'h0001, 16'hFFFF); wait_idle();
    send(5'd5, 16'h00F0, 16'h0000); wait_idle();
    send(5'd31, 16'h1234, 16'h5678); wait_idle();
    send(5'd10, 16'hFFFF, 16'hFFFF); wait_idle();

    // Backpressure: result must hold while a stray request is dropped.
    or_mode = 1;
    send(5'd4, 16'hAAAA, 16'hFFFF);
    for (int n = 0; n < 40 && !out_valid; n++) cycle(1'b0, 5'd0, 16'd0, 16'd0);
    for (int k = 0; k < 5; k++) begin
      cycle(k == 2, 5'd0, 16'h1111, 16'h2222);
      chk(z == 16'h5555 && out_valid, "bp_hold", 32'({out_valid, z}), 32'h15555);
      chk(in_ready == 1'b0, "bp_in_ready", 32'(in_ready), 32'd0);
    end
    or_mode = 2;
    wait_idle();

    // Reset in the middle of a multiply.
    send(5'd9, 16'h0123, 16'h0045);
    repeat (6) cycle(1'b0, 5'd0, 16'd0, 16'd0);
    #2;
    reset_n = 1'b0;
    #1;
    chk(out_valid == 1'b0, "midrst_out_valid", 32'(out_valid), 32'd0);
    chk(z == '0, "midrst_z", 32'(z), 32'd0);
    chk(in_ready == 1'b0, "midrst_in_ready", 32'(in_ready), 32'd0);
    q.delete();
    @(posedge clk);
    #2;
    reset_n = 1'b1;
    #1;
    chk(in_ready == 1'b1, "post_rst_in_ready", 32'(in_ready), 32'd1);
    send(5'd2, 16'h0F0F, 16'h00FF);
    wait_idle();

    // Randomized traffic with random backpressure.
    or_mode = 0;
    for (int i = 0; i < 400; i++) begin
      logic [4:0]  op;
      logic [15:0] a;
      logic [15:0] b;
      op = (($urandom % 8) == 0) ? 5'($urandom) : 5'($urandom % 10);
      a  = (($urandom % 8) == 0) ? corners[$urandom % 5] : 16'($urandom);
      b  = (($urandom % 8) == 0) ? corners[$urandom % 5] : 16'($urandom);
      cycle(($urandom % 3) == 0, op, a, b);
    end
    or_mode = 2;
    wait_idle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
